// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - snapshots tracking results and sends them as an 11-byte 8N1 UART packet
`timescale 1ns/1ps
module result_uart_tx #(
   parameter int          CLKS_PER_BIT = 87,
   parameter logic [7:0]  HDR0         = 8'hA5,
   parameter logic [7:0]  HDR1         = 8'h5A
) (
   input  logic        clk_10M,
   input  logic        rst,
   input  logic        send_req,
   input  logic [31:0] drive_frequency,
   input  logic [15:0] phase_fft,
   input  logic [9:0]  max_idx_v,
   output logic        uart_tx,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   localparam int TW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [TW-1:0] bit_timer;
   logic [2:0]    bit_idx;
   logic [3:0]    byte_idx;
   logic [31:0]   snap_freq;
   logic [15:0]   snap_phase;
   logic [9:0]    snap_idx;
   logic [7:0]    shreg;
   logic [7:0]    cur_byte;
   logic [7:0]    checksum;
   logic          bit_end;

   // Checksum covers the eight payload bytes only; headers are excluded.
   always_comb begin
      checksum = snap_freq[31:24] + snap_freq[23:16] + snap_freq[15:8] + snap_freq[7:0]
               + snap_phase[15:8] + snap_phase[7:0]
               + {6'b0, snap_idx[9:8]} + snap_idx[7:0];
   end

   always_comb begin
      cur_byte = HDR0;
      case (byte_idx)
         4'd0:    cur_byte = HDR0;
         4'd1:    cur_byte = HDR1;
         4'd2:    cur_byte = snap_freq[31:24];
         4'd3:    cur_byte = snap_freq[23:16];
         4'd4:    cur_byte = snap_freq[15:8];
         4'd5:    cur_byte = snap_freq[7:0];
         4'd6:    cur_byte = snap_phase[15:8];
         4'd7:    cur_byte = snap_phase[7:0];
         4'd8:    cur_byte = {6'b0, snap_idx[9:8]};
         4'd9:    cur_byte = snap_idx[7:0];
         4'd10:   cur_byte = checksum;
         default: cur_byte = HDR0;
      endcase
   end

   assign bit_end = (bit_timer == TW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk_10M or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         bit_timer  <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         snap_freq  <= '0;
         snap_phase <= '0;
         snap_idx   <= '0;
         shreg      <= '0;
         uart_tx    <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (send_req && state != IDLE)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (send_req) begin
                  snap_freq  <= drive_frequency;
                  snap_phase <= phase_fft;
                  snap_idx   <= max_idx_v;
                  state      <= START;
                  uart_tx    <= 1'b0;
                  busy       <= 1'b1;
                  overrun    <= 1'b0;
                  bit_timer  <= '0;
                  bit_idx    <= '0;
                  byte_idx   <= '0;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_timer <= '0;
                  bit_idx   <= '0;
                  state     <= DATA;
                  uart_tx   <= cur_byte[0];
                  shreg     <= {1'b0, cur_byte[7:1]};
               end else begin
                  bit_timer <= bit_timer + TW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_timer <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  bit_timer <= bit_timer + TW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  bit_timer <= '0;
                  if (byte_idx < 4'd10) begin
                     byte_idx <= byte_idx + 4'd1;
                     state    <= START;
                     uart_tx  <= 1'b0;
                  end else begin
                     byte_idx <= '0;
                     bit_idx  <= '0;
                     state    <= IDLE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end
               end else begin
                  bit_timer <= bit_timer + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - directed scoreboard bench for result_uart_tx
`timescale 1ns/1ps
module tb_result_uart_tx;

   localparam int CPB     = 87;
   localparam int PKT_CYC = 11 * 10 * CPB;

   logic        clk_10M = 1'b0;
   logic        rst;
   logic        send_req;
   logic [31:0] drive_frequency;
   logic [15:0] phase_fft;
   logic [9:0]  max_idx_v;
   logic        uart_tx;
   logic        busy;
   logic        done;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         busy_q[$];
   int         done_cnt = 0;
   int         done_bad = 0;

   result_uart_tx dut (
      .clk_10M         (clk_10M),
      .rst             (rst),
      .send_req        (send_req),
      .drive_frequency (drive_frequency),
      .phase_fft       (phase_fft),
      .max_idx_v       (max_idx_v),
      .uart_tx         (uart_tx),
      .busy            (busy),
      .done            (done),
      .overrun         (overrun)
   );

   always #50 clk_10M = ~clk_10M;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push_expected(input logic [31:0] f, input logic [15:0] p, input logic [9:0] m);
      logic [7:0] pl[8];
      logic [7:0] sum;
      pl[0] = f[31:24]; pl[1] = f[23:16]; pl[2] = f[15:8]; pl[3] = f[7:0];
      pl[4] = p[15:8];  pl[5] = p[7:0];   pl[6] = {6'b0, m[9:8]}; pl[7] = m[7:0];
      sum = 8'h00;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(pl[i]);
         sum = sum + pl[i];
      end
      exp_q.push_back(sum);
   endtask

   // sync=1 waits for a fresh negedge first; sync=0 requests in the current cycle.
   task automatic send(input logic [31:0] f, input logic [15:0] p, input logic [9:0] m,
                       input bit sync, input bit zero_after);
      if (sync) @(negedge clk_10M);
      drive_frequency = f;
      phase_fft       = p;
      max_idx_v       = m;
      send_req        = 1'b1;
      push_expected(f, p, m);
      @(negedge clk_10M);
      send_req = 1'b0;
      if (zero_after) begin
         drive_frequency = '0;
         phase_fft       = '0;
         max_idx_v       = '0;
      end
      chk("start_busy", busy, 1'b1);
      chk("start_bit", uart_tx, 1'b0);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk_10M);
         n++;
      end while (done !== 1'b1 && n < PKT_CYC + 2000);
      chk("done_seen", done, 1'b1);
      chk("done_busy_low", busy, 1'b0);
   endtask

   task automatic check_pkts();
      int k = 0;
      chk("rx_count", rx_q.size(), exp_q.size());
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         chk($sformatf("rx_byte%0d", k), rx_q.pop_front(), exp_q.pop_front());
         k++;
      end
      exp_q.delete();
      rx_q.delete();
   endtask

   task automatic check_busy(input int n);
      chk("busy_runs", busy_q.size(), n);
      foreach (busy_q[i]) chk($sformatf("busy_len%0d", i), busy_q[i], PKT_CYC);
      busy_q.delete();
   endtask

   // Busy run lengths and done-pulse framing.
   initial begin : mon
      int   run;
      logic prev_busy;
      run = 0;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk_10M);
         if (busy === 1'b1) run++;
         else if (run > 0) begin
            busy_q.push_back(run);
            run = 0;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0 || prev_busy !== 1'b1) done_bad++;
         end
         prev_busy = busy;
      end
   end

   // UART receiver: samples every cycle, checks each bit is held CPB cycles.
   initial begin : decoder
      logic [7:0] data;
      logic       v0;
      bit         aborted, stable, stop_ok;
      forever begin
         @(negedge clk_10M);
         if (rst === 1'b1 && uart_tx === 1'b0) begin
            aborted = 0; stable = 1; stop_ok = 1; data = '0; v0 = 1'b0;
            for (int b = 0; b < 10; b++) begin
               for (int s = 0; s < CPB; s++) begin
                  if (b != 0 || s != 0) @(negedge clk_10M);
                  if (rst !== 1'b1) aborted = 1;
                  if (s == 0) v0 = uart_tx;
                  else if (uart_tx !== v0) stable = 0;
                  if (s == CPB / 2) begin
                     if (b >= 1 && b <= 8) data[b-1] = uart_tx;
                     if (b == 9) stop_ok = (uart_tx === 1'b1);
                  end
               end
            end
            if (!aborted) begin
               chk("bit_stable", stable, 1'b1);
               chk("stop_bit", stop_ok, 1'b1);
               rx_q.push_back(data);
            end
         end
      end
   end

   initial begin : main
      int idle_bad;
      rst = 1'b0; send_req = 1'b0;
      drive_frequency = '0; phase_fft = '0; max_idx_v = '0;
      #100;
      chk("rst_tx", uart_tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      #45 rst = 1'b1;
      idle_bad = 0;
      repeat (200) begin
         @(negedge clk_10M);
         if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) idle_bad++;
      end
      chk("idle_quiet", idle_bad, 0);

      // Single packet, then the same values with inputs cleared right after accept.
      send(32'h000186A0, 16'hFF38, 10'h12A, 1, 0);
      wait_done();
      repeat (2) @(negedge clk_10M);
      check_pkts();
      check_busy(1);

      send(32'h000186A0, 16'hFF38, 10'h12A, 1, 1);
      wait_done();
      repeat (2) @(negedge clk_10M);
      check_pkts();
      check_busy(1);

      // Overrun mid-packet, then back-to-back requests in the done cycles.
      send(32'h12345678, 16'h7FFF, 10'h3FF, 1, 0);
      repeat (1000) @(negedge clk_10M);
      send_req = 1'b1;
      @(negedge clk_10M);
      send_req = 1'b0;
      chk("overrun_set", overrun, 1'b1);
      chk("overrun_busy", busy, 1'b1);
      wait_done();
      chk("overrun_sticky", overrun, 1'b1);
      send(32'hDEADBEEF, 16'h8000, 10'h001, 0, 0);
      chk("overrun_clear", overrun, 1'b0);
      wait_done();
      send(32'hFFFFFFFF, 16'hFFFF, 10'h2C3, 0, 0);
      wait_done();
      repeat (2) @(negedge clk_10M);
      check_pkts();
      check_busy(3);

      // Asynchronous reset during byte 5, then a clean packet.
      send(32'hCAFEF00D, 16'h0123, 10'h155, 1, 0);
      repeat (3700) @(negedge clk_10M);
      #20 rst = 1'b0;
      #1;
      chk("midrst_tx", uart_tx, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      repeat (10) @(negedge clk_10M);
      chk("midrst_overrun", overrun, 1'b0);
      rst = 1'b1;
      busy_q.delete(); rx_q.delete(); exp_q.delete();
      repeat (1000) @(negedge clk_10M);
      chk("post_rst_idle", uart_tx, 1'b1);
      send(32'h0BADC0DE, 16'hFC18, 10'h2A5, 1, 0);
      wait_done();
      repeat (2) @(negedge clk_10M);
      check_pkts();
      check_busy(1);

      chk("done_pulses", done_cnt, 6);
      chk("done_framing", done_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
Transmitter side of the FPGA-to-STM32 result link. On a send request it snapshots the current tracking results: drive frequency word, FFT phase difference and voltage peak bin index. It frames them into an 11-byte packet and serialises the packet as 8N1 UART back to the STM32. It sits beside top in the 10 MHz domain and is the return path for the drive_frequency the STM32 supplies.

Parameters:
CLKS_PER_BIT, 87, clk_10M cycles per UART bit (10 MHz / 115200, rounded).
HDR0, 8'hA5, first header byte.
HDR1, 8'h5A, second header byte.

Ports:
clk_10M  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
send_req  input  1  one-cycle request to transmit a packet.
drive_frequency  input  32  frequency word to report.
phase_fft  input  16  signed phase difference (two's complement).
max_idx_v  input  10  voltage FFT peak bin index.
uart_tx  output  1  serial line; idle high.
busy  output  1  packet in progress.
done  output  1  one-cycle pulse at end of packet.
overrun  output  1  sticky flag: send_req arrived while busy.

Behaviour:
- Reset (rst=0, asynchronous): uart_tx=1, busy=0, done=0, overrun=0, FSM=IDLE, all counters 0. Takes effect immediately, including mid-packet. After release, the line stays high until the next accepted send_req.
- Accept: send_req=1 in IDLE at edge N. The three inputs are latched into a snapshot at that same edge. Input changes after N do not affect the packet. busy=1 and uart_tx=0 (start bit) from cycle N+1.
- Packet byte order, 11 bytes:
  - HDR0, HDR1
  - drive_frequency[31:24], [23:16], [15:8], [7:0]
  - phase_fft[15:8], [7:0]
  - {6'b0, max_idx_v[9:8]}, max_idx_v[7:0]
  - checksum = 8-bit sum modulo 256 of the 8 payload bytes (bytes 3-10, headers excluded).
- Byte framing:
  - Start bit 0, then 8 data bits LSB first, then 1 stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - No idle gap between bytes: the next start bit immediately follows the previous stop bit.
- FSM states:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if byte_idx < 10 (increment byte_idx).
  - STOP -> IDLE at end of the last stop bit.
- Counters:
  - bit-timer 0..CLKS_PER_BIT-1, wraps.
  - bit_idx 0..7.
  - byte_idx 0..10.
- Timing: total packet time = 11 × 10 × CLKS_PER_BIT = 9570 cycles at default. busy is high for exactly 9570 cycles.
- done: 1 in the first cycle after the final stop bit, the same cycle busy returns to 0 and the FSM reaches IDLE. 0 otherwise.
- Back-to-back: send_req in the cycle done=1 is accepted (FSM is IDLE). The next start bit begins the following cycle.
- send_req while busy: ignored, packet unaffected, overrun set to 1. overrun clears only on reset or on the next accepted send_req. If overrun is set and cleared in the same cycle, the clear wins.
- Checksum: computed from the snapshot registers. It may be accumulated per byte or summed combinationally, but must be valid by byte 11.
- uart_tx is a registered output (glitch-free).

Test Plan:
1. Reset sequence: hold rst=0 for 145 ns, release -> uart_tx=1, busy=0, done=0, overrun=0; no activity for 20 µs.
2. Single packet: drive_frequency=32'h000186A0, phase_fft=16'hFF38, max_idx_v=10'h12A, send_req pulse -> decoded bytes A5 5A 00 01 86 A0 FF 38 01 2A 89. busy high 9570 cycles, then one done pulse. Every bit lasts 87 cycles.
3. Snapshot: change all inputs to 0 one cycle after accept -> packet still as in 2.
4. Overrun: send_req again 1000 cycles into a packet -> packet unchanged, overrun=1. Next send_req after done -> accepted, overrun=0.
5. Back-to-back: send_req coincident with done -> second start bit begins the next cycle; total busy 19140 cycles with a single-cycle low gap on busy.
6. Reset mid-packet: rst=0 during byte 5 -> uart_tx=1 and busy=0 immediately (asynchronously). A new request after release sends a full, correct packet from HDR0.
